fetch_queue: RTL and testbench

Instruction fetch queue between the f2/imem stage and dual-issue decode. Accepts a 64-bit fetch group (one or two 32-bit instructions) per cycle from instruction memory and presents the two oldest queued instructions, with their PCs, to decode slots 0 and 1. Decode may consume 0, 1 or 2 per cycle. A redirect flush discards all queued instructions. The queue decouples fetch from decode stalls and handles fetch groups that are not 8-byte aligned.

---
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: takes 64-bit fetch groups from imem and presents the
// two oldest instructions with their PCs to the dual-issue decode slots.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [63:0]              fetch_data_i,
  output logic                     fetch_ready_o,
  output logic [31:0]              inst0_o,
  output logic [31:0]              inst1_o,
  output logic [31:0]              pc0_o,
  output logic [31:0]              pc1_o,
  output logic                     valid0_o,
  output logic                     valid1_o,
  input  logic [1:0]               deq_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] COUNT_TWO = CW'(2);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [AW:0]   head_r;
  logic [AW:0]   tail_r;
  logic [CW-1:0] count_r;

  logic          ready_s;
  logic          enq_fire_s;
  logic          enq_two_s;
  logic [1:0]    enq_n_s;
  logic [1:0]    deq_req_s;
  logic [1:0]    deq_eff_s;
  logic [31:0]   base_pc_s;
  logic [AW-1:0] head_idx_s;
  logic [AW-1:0] head1_idx_s;
  logic [AW-1:0] tail_idx_s;
  logic [AW-1:0] tail1_idx_s;
  logic [AW:0]   head_next_s;
  logic [AW:0]   tail_next_s;
  logic [CW-1:0] count_next_s;
  logic          valid0_s;
  logic          valid1_s;

  // Enqueue/dequeue decision and next-state pointer arithmetic
  always_comb begin
    ready_s    = (count_r <= READY_MAX);
    enq_fire_s = fetch_valid_i && ready_s && !flush_i;
    enq_two_s  = ~fetch_pc_i[2];
    base_pc_s  = fetch_pc_i & 32'hFFFF_FFFC;

    if (enq_fire_s) begin
      if (enq_two_s) begin
        enq_n_s = 2'd2;
      end else begin
        enq_n_s = 2'd1;
      end
    end else begin
      enq_n_s = 2'd0;
    end

    case (deq_i)
      2'd0:    deq_req_s = 2'd0;
      2'd1:    deq_req_s = 2'd1;
      default: deq_req_s = 2'd2;
    endcase

    // Never consume more than is present; count is below 2 whenever this clips.
    if ({{(CW-2){1'b0}}, deq_req_s} > count_r) begin
      deq_eff_s = count_r[1:0];
    end else begin
      deq_eff_s = deq_req_s;
    end

    head_idx_s  = head_r[AW-1:0];
    head1_idx_s = head_idx_s + IDX_ONE;
    tail_idx_s  = tail_r[AW-1:0];
    tail1_idx_s = tail_idx_s + IDX_ONE;

    if (flush_i) begin
      head_next_s  = '0;
      tail_next_s  = '0;
      count_next_s = '0;
    end else begin
      head_next_s  = head_r + {{(AW-1){1'b0}}, deq_eff_s};
      tail_next_s  = tail_r + {{(AW-1){1'b0}}, enq_n_s};
      count_next_s = count_r + {{(CW-2){1'b0}}, enq_n_s}
                             - {{(CW-2){1'b0}}, deq_eff_s};
    end
  end

  // Entry storage; contents are don't-care while invalid, so no reset
  always_ff @(posedge clock_i) begin
    if (enq_fire_s) begin
      if (enq_two_s) begin
        inst_mem_r[tail_idx_s]  <= fetch_data_i[31:0];
        pc_mem_r[tail_idx_s]    <= base_pc_s;
        inst_mem_r[tail1_idx_s] <= fetch_data_i[63:32];
        pc_mem_r[tail1_idx_s]   <= base_pc_s + 32'd4;
      end else begin
        inst_mem_r[tail_idx_s]  <= fetch_data_i[63:32];
        pc_mem_r[tail_idx_s]    <= base_pc_s;
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
    end
  end

  // Slot outputs are muxes of registered state only, gated to zero when invalid
  always_comb begin
    valid0_s      = (count_r != '0);
    valid1_s      = (count_r >= COUNT_TWO);
    valid0_o      = valid0_s;
    valid1_o      = valid1_s;
    count_o       = count_r;
    fetch_ready_o = ready_s;
    if (valid0_s) begin
      inst0_o = inst_mem_r[head_idx_s];
      pc0_o   = pc_mem_r[head_idx_s];
    end else begin
      inst0_o = 32'd0;
      pc0_o   = 32'd0;
    end
    if (valid1_s) begin
      inst1_o = inst_mem_r[head1_idx_s];
      pc1_o   = pc_mem_r[head1_idx_s];
    end else begin
      inst1_o = 32'd0;
      pc1_o   = 32'd0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue with a scoreboard queue modelling the
// expected queue contents, plus hand-written reset sequences.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_pc_i = 32'd0;
  logic [63:0] fetch_data_i = 64'd0;
  logic [1:0]  deq_i = 2'd0;
  logic        fetch_ready_o;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        valid0_o, valid1_o;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .fetch_data_i(fetch_data_i), .fetch_ready_o(fetch_ready_o),
    .inst0_o(inst0_o), .inst1_o(inst1_o), .pc0_o(pc0_o), .pc1_o(pc1_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .deq_i(deq_i),
    .count_o(count_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [63:0] data;
    logic [1:0]  deq;
    logic        fl;
    int          exp_count;
    logic        exp_ready;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic [63:0] data,
                              input logic [1:0] deq, input logic fl, input int ec, input logic er);
    vec_t v;
    v.fv = fv; v.pc = pc; v.data = data; v.deq = deq; v.fl = fl;
    v.exp_count = ec; v.exp_ready = er;
    return v;
  endfunction

  // Advance the reference queue by one clock edge with the given inputs.
  task automatic model_step(input vec_t v);
    int          n;
    int          d;
    logic        rdy;
    logic [31:0] pcb;
    n   = sb.size();
    rdy = ((DEPTH - n) >= 2);
    if (v.fl) begin
      sb.delete();
    end else begin
      d = (v.deq == 2'd3) ? 2 : int'(v.deq);
      if (d > n) d = n;
      repeat (d) void'(sb.pop_front());
      if (v.fv && rdy) begin
        pcb = v.pc & 32'hFFFF_FFFC;
        if (!v.pc[2]) begin
          sb.push_back('{v.data[31:0], pcb});
          sb.push_back('{v.data[63:32], pcb + 32'd4});
        end else begin
          sb.push_back('{v.data[63:32], pcb});
        end
      end
    end
  endtask

  task automatic check_slots(input string tag);
    int   n;
    ent_t e0;
    ent_t e1;
    n  = sb.size();
    e0 = '{32'd0, 32'd0};
    e1 = '{32'd0, 32'd0};
    if (n >= 1) e0 = sb[0];
    if (n >= 2) e1 = sb[1];
    check({tag, ".count"},  32'(count_o),  32'(n));
    check({tag, ".ready"},  32'(fetch_ready_o), 32'((DEPTH - n) >= 2));
    check({tag, ".valid0"}, 32'(valid0_o), 32'(n >= 1));
    check({tag, ".valid1"}, 32'(valid1_o), 32'(n >= 2));
    check({tag, ".inst0"},  inst0_o, e0.inst);
    check({tag, ".pc0"},    pc0_o,   e0.pc);
    check({tag, ".inst1"},  inst1_o, e1.inst);
    check({tag, ".pc1"},    pc1_o,   e1.pc);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clock_i);
    fetch_valid_i = v.fv;
    fetch_pc_i    = v.pc;
    fetch_data_i  = v.data;
    deq_i         = v.deq;
    flush_i       = v.fl;
    model_step(v);
    @(posedge clock_i);
    #1;
    check({tag, ".tbl_count"}, 32'(count_o), 32'(v.exp_count));
    check({tag, ".tbl_ready"}, 32'(fetch_ready_o), 32'(v.exp_ready));
    check_slots(tag);
  endtask

  initial begin
    // Aligned fill, overflow drop, odd targets, partial consume, flush priority
    vecs.push_back(mk(1'b1, 32'h00, {32'h22, 32'h11}, 2'd0, 1'b0, 2, 1'b1));
    vecs.push_back(mk(1'b1, 32'h08, {32'h44, 32'h33}, 2'd0, 1'b0, 4, 1'b0));
    vecs.push_back(mk(1'b1, 32'h10, {32'h99, 32'h98}, 2'd0, 1'b0, 4, 1'b0));
    vecs.push_back(mk(1'b0, 32'h00, 64'd0,            2'd2, 1'b0, 2, 1'b1));
    vecs.push_back(mk(1'b1, 32'h10, {32'h66, 32'h55}, 2'd1, 1'b0, 3, 1'b0));
    vecs.push_back(mk(1'b1, 32'h18, {32'h78, 32'h77}, 2'd1, 1'b0, 2, 1'b1));
    vecs.push_back(mk(1'b0, 32'h00, 64'd0,            2'd0, 1'b1, 0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0C, {32'hBB, 32'hAA}, 2'd0, 1'b0, 1, 1'b1));
    vecs.push_back(mk(1'b1, 32'h20, {32'h66, 32'h55}, 2'd0, 1'b0, 3, 1'b0));
    vecs.push_back(mk(1'b1, 32'h28, {32'h12, 32'h34}, 2'd2, 1'b1, 0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h43, {32'h88, 32'h77}, 2'd0, 1'b0, 2, 1'b1));
    vecs.push_back(mk(1'b1, 32'h4F, {32'hCC, 32'hDD}, 2'd0, 1'b0, 3, 1'b0));
    vecs.push_back(mk(1'b1, 32'h50, {32'hEE, 32'hEF}, 2'd1, 1'b0, 2, 1'b1));
    vecs.push_back(mk(1'b0, 32'h00, 64'd0,            2'd1, 1'b0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h00, 64'd0,            2'd3, 1'b0, 0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h00, 64'd0,            2'd3, 1'b0, 0, 1'b1));
    // Streaming across the pointer wrap: enqueue 2 and dequeue 2 every cycle
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p;
      p = 32'h100 + 32'(8 * i);
      vecs.push_back(mk(1'b1, p, {32'hA000_0000 | (p + 32'd4), 32'hA000_0000 | p},
                        2'd2, 1'b0, 2, 1'b1));
    end
    // Enqueue at count = DEPTH-2 fills the queue
    vecs.push_back(mk(1'b1, 32'h200, {32'h5151, 32'h5050}, 2'd0, 1'b0, 4, 1'b0));

    // Reset state
    repeat (2) @(posedge clock_i);
    #1;
    check_slots("reset");
    check("reset.ready_hw", 32'(fetch_ready_o), 32'd1);
    @(negedge clock_i);
    reset_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-stream with count = 4, checked before the next edge
    #2;
    fetch_valid_i = 1'b0;
    deq_i         = 2'd0;
    flush_i       = 1'b0;
    reset_n_i     = 1'b0;
    #1;
    sb.delete();
    check("areset.count",  32'(count_o), 32'd0);
    check("areset.ready",  32'(fetch_ready_o), 32'd1);
    check("areset.valid0", 32'(valid0_o), 32'd0);
    check("areset.inst0",  inst0_o, 32'd0);
    check("areset.pc1",    pc1_o, 32'd0);
    check_slots("areset");
    @(negedge clock_i);
    reset_n_i = 1'b1;
    apply(mk(1'b1, 32'h300, {32'h3333, 32'h3030}, 2'd0, 1'b0, 2, 1'b1), "resume");
    apply(mk(1'b1, 32'h30C, {32'h4444, 32'h4040}, 2'd1, 1'b0, 2, 1'b1), "resume_odd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
